// File: rtl/sumador_serie.sv
// rtl/sumador_serie.sv - digit-serial WIDTH-bit adder, DIGIT bits per clock, start/busy/done handshake
// Optional subtract mode: define SUMADOR_SERIE_SUB_EN to add the sub port (a - b - cin).
module sumador_serie #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUMADOR_SERIE_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS) + 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("sumador_serie: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   digit_sum;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SUMADOR_SERIE_SUB_EN
  // Subtraction as a + ~b + ~cin; the final carry is then NOT borrow.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? ~cin : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign accept    = start && (state != S_RUN);
  assign last_step = (cnt == CW'(STEPS - 1));
  assign digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // New digit enters from the MSB so the LSB digit ends up at bit 0 after STEPS shifts.
  assign res_nxt   = (res >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= c_load;
      res   <= '0;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= digit_sum[DIGIT];
      res   <= res_nxt;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        sum  <= res_nxt;
        cout <= digit_sum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_sumador_serie.sv
// tb/tb_sumador_serie.sv - scoreboard bench for sumador_serie (W8/D1 and W4/D2 instances)
module tb_sumador_serie;

  localparam int W1 = 8;
  localparam int D1 = 1;
  localparam int W2 = 4;
  localparam int D2 = 2;

  typedef struct {
    logic [16:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic          start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [W1-1:0] a1 = '0, b1 = '0;
  logic          busy1, done1, cout1;
  logic [W1-1:0] sum1;

  logic          start2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
  logic [W2-1:0] a2 = '0, b2 = '0;
  logic          busy2, done2, cout2;
  logic [W2-1:0] sum2;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [16:0] hold1 = '0;
  logic [16:0] hold2 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sumador_serie #(.WIDTH(W1), .DIGIT(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SUMADOR_SERIE_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  sumador_serie #(.WIDTH(W2), .DIGIT(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SUMADOR_SERIE_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic, {cout,sum} packed as cout<<w | sum.
  function automatic logic [16:0] model(input int w, input int av, input int bv, input int cv, input int sv);
    int m;
    int d;
    m = 1 << w;
    if (sv != 0) begin
      d = av - bv - cv;
      d = ((d % m) + m) % m;
      if (av >= bv + cv) d = d + m;
      return 17'(d);
    end
    return 17'(av + bv + cv);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done1) begin
        if (q1.size() == 0) begin
          chk(0, "dut1_spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk({8'd0, cout1, sum1} == e.val, "dut1_result", {cout1, sum1}, e.val);
          chk(cyc == e.cyc, "dut1_latency", cyc, e.cyc);
        end
        hold1 = {8'd0, cout1, sum1};
      end else begin
        chk({8'd0, cout1, sum1} == hold1, "dut1_hold", {cout1, sum1}, hold1);
      end
      if (done2) begin
        if (q2.size() == 0) begin
          chk(0, "dut2_spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk({12'd0, cout2, sum2} == e.val, "dut2_result", {cout2, sum2}, e.val);
          chk(cyc == e.cyc, "dut2_latency", cyc, e.cyc);
        end
        hold2 = {12'd0, cout2, sum2};
      end
    end
  end

  task automatic issue1(input int av, input int bv, input int cv, input int sv);
    int n;
    n = 0;
    while (busy1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk(0, "dut1_accept_timeout", n, 0);
    a1 = W1'(av); b1 = W1'(bv); cin1 = cv[0]; sub1 = sv[0];
    start1 = 1'b1;
    q1.push_back('{val: model(W1, av, bv, cv, sv), cyc: cyc + 1 + W1 / D1});
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic issue2(input int av, input int bv, input int cv);
    int n;
    n = 0;
    while (busy2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk(0, "dut2_accept_timeout", n, 0);
    a2 = W2'(av); b2 = W2'(bv); cin2 = cv[0];
    start2 = 1'b1;
    q2.push_back('{val: model(W2, av, bv, cv, 0), cyc: cyc + 1 + W2 / D2});
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(q1.size() == 0 && q2.size() == 0, "drain", q1.size() + q2.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk(busy1 == 0 && done1 == 0, "reset_ctrl", {busy1, done1}, 0);
    chk(sum1 == 0 && cout1 == 0, "reset_out", {cout1, sum1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripples through every digit; busy exactly 8 cycles.
    issue1(8'hFF, 8'h01, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk(busy1 == 1 && done1 == 0, "t1_busy", {busy1, done1}, 2);
      @(posedge clk); #1;
    end
    chk(done1 == 1 && busy1 == 0, "t1_done", {busy1, done1}, 1);
    chk({cout1, sum1} == 9'h100, "t1_value", {cout1, sum1}, 9'h100);
    drain();

    // Start held during RUN with other operands must be ignored.
    issue1(8'h3C, 8'hC5, 1, 0);
    for (int i = 0; i < 4; i++) begin
      a1 = W1'($urandom); b1 = W1'($urandom); start1 = 1'b1;
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    drain();

    // Reset at RUN step 4 aborts with no done pulse.
    issue1(8'hAA, 8'h55, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk(busy1 == 0 && done1 == 0, "t4_ctrl", {busy1, done1}, 0);
    chk(sum1 == 0 && cout1 == 0, "t4_out", {cout1, sum1}, 0);
    q1.delete();
    q2.delete();
    hold1 = '0;
    hold2 = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue1(8'h12, 8'h34, 0, 0);
    drain();

    // Back-to-back: second start lands on the DONE cycle.
    issue1(8'h7F, 8'h80, 1, 0);
    issue1(8'h10, 8'h20, 0, 0);
    chk(busy1 == 1, "t5_no_gap", busy1, 1);
    drain();
    chk({cout1, sum1} == 9'h030, "t5_value", {cout1, sum1}, 9'h030);

`ifdef SUMADOR_SERIE_SUB_EN
    issue1(8'h05, 8'h07, 0, 1);
    issue1(8'h07, 8'h05, 1, 1);
    drain();
`endif

    // Exhaustive W=4 D=2, back-to-back.
    for (int v = 0; v < 512; v++) begin
      issue2(v & 15, (v >> 4) & 15, (v >> 8) & 1);
    end
    drain();

    // Random W=8 D=1, occasionally with idle gaps.
    for (int i = 0; i < 150; i++) begin
      int sv;
      sv = 0;
`ifdef SUMADOR_SERIE_SUB_EN
      sv = int'($urandom_range(0, 1));
`endif
      issue1(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), sv);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
